// File: rtl/cache_pkg.sv
// Shared constants, state encoding and address helper for the cache refill path.
package cache_pkg;

  localparam int TAG_W    = 52;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 6;
  localparam int BEAT_W   = 64;
  localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;

  localparam int BYTES_PER_BEAT  = BEAT_W / 8;
  localparam int BEATS_PER_BLOCK = (2 ** OFFSET_W) * 8 / BEAT_W;
  localparam int BYTE_CNT_W      = $clog2(BYTES_PER_BEAT);
  localparam int BEAT_CNT_W      = $clog2(BEATS_PER_BLOCK);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_BLOCK - 1);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_BEAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    BEAT,
    WRITE,
    COMMIT
  } refill_state_t;

  // Byte address of the first byte of a block.
  function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0]   tag,
                                                   input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_refill_serializer.sv
// Holds one memory beat and presents it one byte at a time, lowest byte first.
module cache_refill_serializer
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [BEAT_W-1:0]     i_data,
  input  logic                  i_advance,
  output logic [7:0]            o_byte,
  output logic [BYTE_CNT_W-1:0] o_byte_idx,
  output logic                  o_last
);

  logic [BEAT_W-1:0]     r_buf;
  logic [BYTE_CNT_W-1:0] r_byte_idx;

  // Capture a beat and restart at byte 0, or step to the next byte.
  // NOTE: the data buffer is reset too, so the byte output reads 0 out of reset
  // instead of X; it is a single register, not a RAM, so this is cheap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf      <= '0;
      r_byte_idx <= '0;
    end else if (i_load) begin
      r_buf      <= i_data;
      r_byte_idx <= '0;
    end else if (i_advance) begin
      r_byte_idx <= r_byte_idx + 1'b1;
    end
  end

  assign o_byte     = r_buf[{r_byte_idx, 3'b000} +: 8];
  assign o_byte_idx = r_byte_idx;
  assign o_last     = (r_byte_idx == LAST_BYTE);

endmodule

// File: rtl/cache_refill.sv
// Refill engine: fetch a missing block as beats, write it bytewise, then commit tag/valid.
module cache_refill
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [TAG_W-1:0]    miss_tag,
  input  logic [INDEX_W-1:0]  miss_index,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  input  logic [BEAT_W-1:0]   mem_rdata,
  output logic                ram_wen,
  output logic [INDEX_W-1:0]  ram_index,
  output logic [OFFSET_W-1:0] ram_offset,
  output logic [7:0]          ram_wdata,
  output logic                tag_wen,
  output logic [INDEX_W-1:0]  tag_index,
  output logic [TAG_W-1:0]    tag_value,
  output logic                refill_done
);

  refill_state_t         r_state;
  refill_state_t         w_next_state;
  logic [TAG_W-1:0]      r_tag;
  logic [INDEX_W-1:0]    r_index;
  logic [BEAT_CNT_W-1:0] r_beat;

  logic                  w_accept;
  logic                  w_capture;
  logic                  w_in_write;
  logic                  w_last_byte;
  logic                  w_beat_done;
  logic [7:0]            w_byte;
  logic [BYTE_CNT_W-1:0] w_byte_idx;

  assign w_accept    = (r_state == IDLE) && miss_valid;
  assign w_capture   = (r_state == BEAT) && mem_rvalid;
  assign w_in_write  = (r_state == WRITE);
  assign w_beat_done = w_in_write && w_last_byte;

  cache_refill_serializer u_serializer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_capture),
    .i_data     (mem_rdata),
    .i_advance  (w_in_write),
    .o_byte     (w_byte),
    .o_byte_idx (w_byte_idx),
    .o_last     (w_last_byte)
  );

  // State register; reset drops any refill in flight without committing.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode.
  // NOTE: the default assignment before the case keeps this purely
  // combinational; a missing branch would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (miss_valid)    w_next_state = REQ;
      REQ:     if (mem_req_ready) w_next_state = BEAT;
      BEAT:    if (mem_rvalid)    w_next_state = WRITE;
      WRITE:   if (w_last_byte)   w_next_state = (r_beat == LAST_BEAT) ? COMMIT : BEAT;
      COMMIT:                     w_next_state = IDLE;
      default:                    w_next_state = IDLE;
    endcase
  end

  // Latch the request on acceptance and count beats as each one is fully written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag   <= '0;
      r_index <= '0;
      r_beat  <= '0;
    end else if (w_accept) begin
      r_tag   <= miss_tag;
      r_index <= miss_index;
      r_beat  <= '0;
    end else if (w_beat_done && (r_beat != LAST_BEAT)) begin
      r_beat  <= r_beat + 1'b1;
    end
  end

  // Strobes decoded from state only; data fields come from registers.
  always_comb begin
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    mem_rready    = 1'b0;
    ram_wen       = 1'b0;
    ram_offset    = '0;
    ram_wdata     = '0;
    tag_wen       = 1'b0;
    refill_done   = 1'b0;
    case (r_state)
      IDLE:   miss_ready    = 1'b1;
      REQ:    mem_req_valid = 1'b1;
      BEAT:   mem_rready    = 1'b1;
      WRITE: begin
        ram_wen    = 1'b1;
        ram_offset = {r_beat, w_byte_idx};
        ram_wdata  = w_byte;
      end
      COMMIT: begin
        tag_wen     = 1'b1;
        refill_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_req_addr = block_addr(r_tag, r_index);
  assign ram_index    = r_index;
  assign tag_index    = r_index;
  assign tag_value    = r_tag;

endmodule

// File: tb/tb_cache_refill.sv
// Randomized scoreboard bench for cache_refill with a behavioural memory and block model.
module tb_cache_refill;
  import cache_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                miss_valid;
  logic                miss_ready;
  logic [TAG_W-1:0]    miss_tag;
  logic [INDEX_W-1:0]  miss_index;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic                mem_rvalid;
  logic                mem_rready;
  logic [BEAT_W-1:0]   mem_rdata;
  logic                ram_wen;
  logic [INDEX_W-1:0]  ram_index;
  logic [OFFSET_W-1:0] ram_offset;
  logic [7:0]          ram_wdata;
  logic                tag_wen;
  logic [INDEX_W-1:0]  tag_index;
  logic [TAG_W-1:0]    tag_value;
  logic                refill_done;

  cache_refill dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_tag(miss_tag), .miss_index(miss_index),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .ram_wen(ram_wen), .ram_index(ram_index), .ram_offset(ram_offset),
    .ram_wdata(ram_wdata),
    .tag_wen(tag_wen), .tag_index(tag_index), .tag_value(tag_value),
    .refill_done(refill_done)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [7:0]          data;
  } wr_t;

  typedef struct {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    bit                 chk_lat;
  } commit_t;

  wr_t           exp_wr[$];
  commit_t       exp_commit[$];
  logic [63:0]   mem_beats[$];

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            t0 = 0;
  bit            active = 0;
  bit            req_acc = 0;
  int            writes_seen = 0;
  int            req_cycles = 0;
  logic [63:0]   cur_addr = '0;
  int            req_wait = 0;
  int            stall_pct = 0;
  bit            stray_en = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: answers requests and serves beats in order, with optional stalls and stray valids.
  initial begin
    mem_req_ready = 1'b1;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end else begin
        if (mem_req_valid && req_wait > 0) begin
          mem_req_ready = 1'b0;
          req_wait--;
        end else begin
          mem_req_ready = 1'b1;
        end
        if (mem_req_valid && mem_req_ready) req_acc = 1'b1;
        if (req_acc && mem_beats.size() > 0) begin
          mem_rvalid = ($urandom_range(99) >= stall_pct);
          mem_rdata  = mem_beats[0];
          if (mem_rvalid && mem_rready) void'(mem_beats.pop_front());
        end else begin
          mem_rvalid = stray_en && ($urandom_range(1) == 1);
          mem_rdata  = {$urandom, $urandom};
        end
      end
    end
  end

  // Monitor: samples just after each rising edge and retires expectations.
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst) begin
      check(miss_ready == !active, "miss_ready", 64'(miss_ready), 64'(!active));
      check(!mem_rready || req_acc, "mem_rready_window", 64'(mem_rready), 64'(req_acc));
      check(!(mem_rready && ram_wen), "rready_during_write", 64'(mem_rready), 64'd0);
      if (mem_req_valid) begin
        check(mem_req_addr == cur_addr, "mem_req_addr", mem_req_addr, cur_addr);
        req_cycles++;
      end
      if (ram_wen) begin
        if (exp_wr.size() == 0) begin
          check(1'b0, "unexpected_write", 64'(ram_offset), 64'd0);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check(ram_index  == w.index,  "ram_index",  64'(ram_index),  64'(w.index));
          check(ram_offset == w.offset, "ram_offset", 64'(ram_offset), 64'(w.offset));
          check(ram_wdata  == w.data,   "ram_wdata",  64'(ram_wdata),  64'(w.data));
        end
        writes_seen++;
      end
      check(refill_done == tag_wen, "done_vs_tag_wen", 64'(refill_done), 64'(tag_wen));
      if (tag_wen) begin
        if (exp_commit.size() == 0) begin
          check(1'b0, "unexpected_commit", 64'(tag_index), 64'd0);
        end else begin
          commit_t c;
          c = exp_commit.pop_front();
          check(tag_value == c.tag,   "tag_value", 64'(tag_value), 64'(c.tag));
          check(tag_index == c.index, "tag_index", 64'(tag_index), 64'(c.index));
          check(writes_seen == 64, "bytes_before_commit", 64'(writes_seen), 64'd64);
          if (c.chk_lat) check(cyc - t0 == 74, "latency", 64'(cyc - t0), 64'd74);
        end
        active  = 1'b0;
        req_acc = 1'b0;
      end
    end
  end

  // Issue one miss; expectations are pushed once the request is seen accepted.
  task automatic do_refill(input logic [TAG_W-1:0] tag, input logic [INDEX_W-1:0] idx,
                           input int rw, input int sp, input bit pat, input bit lat);
    logic [63:0] beats[BEATS_PER_BLOCK];
    bit          accepted = 0;
    for (int k = 0; k < BEATS_PER_BLOCK; k++)
      beats[k] = pat ? 64'h0706050403020100 + 64'(k) * 64'h0808080808080808
                     : {$urandom, $urandom};
    @(negedge clk);
    miss_valid = 1'b1;
    miss_tag   = tag;
    miss_index = idx;
    for (int i = 0; i < 500 && !accepted; i++) begin
      if (miss_ready) accepted = 1'b1;
      else @(negedge clk);
    end
    if (!accepted) begin
      check(1'b0, "accept_timeout", 64'(miss_ready), 64'd1);
    end else begin
      for (int k = 0; k < BEATS_PER_BLOCK; k++) begin
        mem_beats.push_back(beats[k]);
        for (int j = 0; j < 8; j++) begin
          wr_t w;
          w.index  = idx;
          w.offset = OFFSET_W'(k * 8 + j);
          w.data   = beats[k][8*j +: 8];
          exp_wr.push_back(w);
        end
      end
      exp_commit.push_back('{tag: tag, index: idx, chk_lat: lat});
      cur_addr    = (64'(tag) << 12) | (64'(idx) << 6);
      t0          = cyc;
      req_acc     = 1'b0;
      req_cycles  = 0;
      writes_seen = 0;
      req_wait    = rw;
      stall_pct   = sp;
      active      = 1'b1;
    end
    @(negedge clk);
    miss_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!active) return;
    end
    check(1'b0, "refill_timeout", 64'(writes_seen), 64'd64);
  endtask

  task automatic check_reset_outputs(input string tag_s);
    check(miss_ready == 1'b1,    {tag_s, "_miss_ready"},    64'(miss_ready), 64'd1);
    check(mem_req_valid == 1'b0, {tag_s, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    check(mem_req_addr == '0,    {tag_s, "_mem_req_addr"},  mem_req_addr, 64'd0);
    check(mem_rready == 1'b0,    {tag_s, "_mem_rready"},    64'(mem_rready), 64'd0);
    check(ram_wen == 1'b0,       {tag_s, "_ram_wen"},       64'(ram_wen), 64'd0);
    check(ram_index == '0,       {tag_s, "_ram_index"},     64'(ram_index), 64'd0);
    check(ram_offset == '0,      {tag_s, "_ram_offset"},    64'(ram_offset), 64'd0);
    check(ram_wdata == '0,       {tag_s, "_ram_wdata"},     64'(ram_wdata), 64'd0);
    check(tag_wen == 1'b0,       {tag_s, "_tag_wen"},       64'(tag_wen), 64'd0);
    check(tag_index == '0,       {tag_s, "_tag_index"},     64'(tag_index), 64'd0);
    check(tag_value == '0,       {tag_s, "_tag_value"},     64'(tag_value), 64'd0);
    check(refill_done == 1'b0,   {tag_s, "_refill_done"},   64'(refill_done), 64'd0);
  endtask

  initial begin
    bit reached;
    rst        = 1'b1;
    miss_valid = 1'b0;
    miss_tag   = '0;
    miss_index = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-wait memory: address and latency.
    do_refill(52'h5, 6'd3, 0, 0, 1'b0, 1'b1);
    wait_done();
    check(req_cycles == 1, "req_one_cycle", 64'(req_cycles), 64'd1);

    // Ramp pattern: each written byte equals its offset.
    do_refill(TAG_W'({$urandom, $urandom}), 6'd3, 0, 0, 1'b1, 1'b1);
    wait_done();

    // Request held off for 5 cycles, random beat stalls.
    do_refill(TAG_W'({$urandom, $urandom}), 6'd17, 5, 40, 1'b0, 1'b0);
    wait_done();
    check(req_cycles == 6, "req_wait_cycles", 64'(req_cycles), 64'd6);

    // A second miss while busy is ignored, then accepted once idle.
    do_refill(TAG_W'({$urandom, $urandom}), 6'd3, 1, 10, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      miss_valid = 1'b1;
      miss_index = 6'd9;
      miss_tag   = TAG_W'({$urandom, $urandom});
      @(negedge clk);
    end
    miss_valid = 1'b0;
    wait_done();
    do_refill(TAG_W'({$urandom, $urandom}), 6'd9, 0, 0, 1'b0, 1'b1);
    wait_done();

    // Asynchronous reset in the middle of beat 4.
    do_refill(TAG_W'({$urandom, $urandom}), 6'd42, 0, 20, 1'b0, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      @(negedge clk);
      if (writes_seen >= 34) reached = 1'b1;
    end
    check(reached, "reach_beat4", 64'(writes_seen), 64'd34);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_wr.delete();
    exp_commit.delete();
    mem_beats.delete();
    active   = 1'b0;
    req_acc  = 1'b0;
    req_wait = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_refill(TAG_W'({$urandom, $urandom}), 6'd42, 0, 0, 1'b0, 1'b1);
    wait_done();

    // Stray read-valids in IDLE, REQ and WRITE.
    stray_en = 1'b1;
    repeat (10) @(negedge clk);
    do_refill(TAG_W'({$urandom, $urandom}), 6'd60, 3, 30, 1'b0, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);
    stray_en = 1'b0;

    // A few fully random refills.
    for (int n = 0; n < 4; n++) begin
      do_refill(TAG_W'({$urandom, $urandom}), INDEX_W'($urandom),
                $urandom_range(4), $urandom_range(50), 1'b0, 1'b0);
      wait_done();
    end

    repeat (3) @(negedge clk);
    check(exp_wr.size() == 0, "writes_left", 64'(exp_wr.size()), 64'd0);
    check(exp_commit.size() == 0, "commits_left", 64'(exp_commit.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
